// File: rtl/spi_pkg.sv
// Shared types for the SPI master shift engine.
//   spi_state_t : engine FSM states
//   spi_mode_t  : SPI clock mode pair {cpol, cpha}
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_bit_shifter.sv
// TX/RX shift register pair for the SPI shift engine.
//   clk, rst_n  : clock, async active-low reset
//   load        : capture tx_data and set up mosi for the latched mode
//   load_mode   : mode presented with load (only cpha is used)
//   tx_data     : word to send, MSB first
//   shift_tx    : put the next TX bit on mosi
//   sample_rx   : shift miso into rx_word (LSB in)
//   miso        : serial input
//   mosi        : serial output (registered)
//   rx_word     : receive shift register contents
module spi_bit_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  spi_mode_t         load_mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              shift_tx,
  input  logic              sample_rx,
  input  logic              miso,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_word
);

  // Holds the bits that have not yet been put on mosi, next one at the MSB.
  logic [DATA_W-1:0] tx_sreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sreg <= '0;
      rx_word <= '0;
      mosi    <= 1'b0;
    end else if (load) begin
      if (load_mode.cpha) begin
        // MSB goes out on the first leading edge.
        tx_sreg <= tx_data;
        mosi    <= 1'b0;
      end else begin
        // MSB must be valid before the first edge, so present it now.
        tx_sreg <= {tx_data[DATA_W-2:0], 1'b0};
        mosi    <= tx_data[DATA_W-1];
      end
    end else begin
      if (shift_tx) begin
        mosi    <= tx_sreg[DATA_W-1];
        tx_sreg <= {tx_sreg[DATA_W-2:0], 1'b0};
      end
      if (sample_rx) begin
        rx_word <= {rx_word[DATA_W-2:0], miso};
      end
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: one DATA_W-bit word per transfer, all four
// CPOL/CPHA modes, paced by an external half-period tick generator.
//   clk, rst_n : clock, async active-low reset
//   tick       : half-SCLK-period strobe (honoured only while tick_en)
//   tick_en    : enable to the tick generator, high while not IDLE
//   start      : transfer request, sampled in IDLE only
//   tx_data    : word to send, latched on accepted start
//   cpol, cpha : SPI mode; cpol tracked while IDLE, cpha latched on start
//   rx_data    : last received word, updated in the done cycle
//   busy, done : status; done is a one-cycle completion pulse
//   sclk, mosi, miso, cs_n : SPI pins
//
// state | meaning
// IDLE  | cs_n high, sclk = cpol_q, waiting for start
// LEAD  | cs_n low, one half period of CS setup before the first edge
// XFER  | 2*DATA_W sclk edges, shifting mosi and sampling miso
// TRAIL | one half period of CS hold, then done
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  output logic              tick_en,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int            EW        = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  spi_state_t        state;
  spi_mode_t         mode_q;
  spi_mode_t         load_mode;
  logic [EW-1:0]     edge_cnt;
  logic [DATA_W-1:0] rx_word;
  logic              tick_ok;
  logic              accept;
  logic              xfer_tick;
  logic              lead_edge;
  logic              last_edge;
  logic              shift_tx;
  logic              sample_rx;

  assign tick_ok   = tick & tick_en;
  assign accept    = (state == IDLE) & start;
  assign xfer_tick = (state == XFER) & tick_ok;
  assign lead_edge = ~edge_cnt[0];
  assign last_edge = (edge_cnt == LAST_EDGE);
  assign load_mode = '{cpol: cpol, cpha: cpha};

  // CPHA=0 samples on leading edges and shifts on trailing ones (holding on
  // the final trailing edge); CPHA=1 is the other way round.
  assign shift_tx  = xfer_tick & (mode_q.cpha ? lead_edge : (~lead_edge & ~last_edge));
  assign sample_rx = xfer_tick & (mode_q.cpha ? ~lead_edge : lead_edge);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      tick_en  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // sclk follows the same value as cpol_q so both settle together.
          mode_q.cpol <= cpol;
          sclk        <= cpol;
          if (start) begin
            state       <= LEAD;
            mode_q.cpha <= cpha;
            edge_cnt    <= '0;
            cs_n        <= 1'b0;
            busy        <= 1'b1;
            tick_en     <= 1'b1;
          end
        end
        LEAD: begin
          if (tick_ok) state <= XFER;
        end
        XFER: begin
          if (tick_ok) begin
            if (last_edge) begin
              state    <= TRAIL;
              edge_cnt <= '0;
              sclk     <= mode_q.cpol;
            end else begin
              edge_cnt <= edge_cnt + EW'(1);
              sclk     <= ~sclk;
            end
          end
        end
        TRAIL: begin
          if (tick_ok) begin
            state   <= IDLE;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            tick_en <= 1'b0;
            rx_data <= rx_word;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  spi_bit_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_mode (load_mode),
    .tx_data   (tx_data),
    .shift_tx  (shift_tx),
    .sample_rx (sample_rx),
    .miso      (miso),
    .mosi      (mosi),
    .rx_word   (rx_word)
  );

endmodule
